multi_seq: RTL and testbench

MULTI_SEQ -- requirements
Module: multi_seq

---
 rtl/multi_seq.sv | 105 ++++++++++
 tb/tb_multi_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Ports: clk, rst (sync, active-high), start, sign_mode, in1, in2 -> out (2W), busy, done.
module multi_seq #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           sign_mode,
   input  logic [W-1:0]   in1,
   input  logic [W-1:0]   in2,
   output logic [2*W-1:0] out,
   output logic           busy,
   output logic           done
);

   localparam int CW = (W > 2) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplier;
   logic           neg;

   logic [W-1:0]   mag1;
   logic [W-1:0]   mag2;
   logic [2*W-1:0] acc_nxt;
   logic [2*W-1:0] prod;

   // Magnitudes: -2^(W-1) maps to 2^(W-1), still fits in W unsigned bits
   always_comb begin
      mag1 = in1;
      mag2 = in2;
      if (sign_mode && in1[W-1])
         mag1 = '0 - in1;
      if (sign_mode && in2[W-1])
         mag2 = '0 - in2;
   end

   // Last step's sum feeds the result directly so out lands on DONE entry
   always_comb begin
      acc_nxt = acc;
      if (mplier[0])
         acc_nxt = acc + mcand;
      prod = acc_nxt;
      if (neg)
         prod = '0 - acc_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         out    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {{W{1'b0}}, mag1};
                  mplier <= mag2;
                  neg    <= sign_mode & (in1[W-1] ^ in2[W-1]);
                  acc    <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(W - 1)) begin
                  out   <= prod;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_seq.sv
// Bench for multi_seq: table vectors, random ops at W=4/8/16, hand corner cases.
// Reference products come from plain integer arithmetic on the operand values.
module tb_multi_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sign_mode;
   logic [31:0] in1;
   logic [31:0] in2;
   logic [7:0]  o4;
   logic [15:0] o8;
   logic [31:0] o16;
   logic [2:0]  bsy;
   logic [2:0]  dn;
   logic [15:0] res8;

   int checks = 0;
   int errors = 0;

   multi_seq #(.W(4)) u4 (
      .clk(clk), .rst(rst), .start(start),
      .sign_mode(sign_mode),
      .in1(in1[3:0]), .in2(in2[3:0]),
      .out(o4), .busy(bsy[0]), .done(dn[0])
   );

   multi_seq #(.W(8)) u8 (
      .clk(clk), .rst(rst), .start(start),
      .sign_mode(sign_mode),
      .in1(in1[7:0]), .in2(in2[7:0]),
      .out(o8), .busy(bsy[1]), .done(dn[1])
   );

   multi_seq #(.W(16)) u16 (
      .clk(clk), .rst(rst), .start(start),
      .sign_mode(sign_mode),
      .in1(in1[15:0]), .in2(in2[15:0]),
      .out(o16), .busy(bsy[2]), .done(dn[2])
   );

   always #5 clk = ~clk;

   function automatic int wid(input int i);
      return (i == 0) ? 4 : (i == 1) ? 8 : 16;
   endfunction

   function automatic logic [63:0] outv(input int i);
      if (i == 0) return {56'd0, o4};
      if (i == 1) return {48'd0, o8};
      return {32'd0, o16};
   endfunction

   // Interpret the low w bits as a number, multiply, keep 2w bits
   function automatic logic [63:0] ref_prod(
      input int w, input logic [31:0] a,
      input logic [31:0] b, input bit sm);
      longint m;
      longint sa;
      longint sb;
      longint p;
      logic [63:0] pm;
      m  = (longint'(1) << w) - 1;
      sa = longint'(a) & m;
      sb = longint'(b) & m;
      if (sm) begin
         if (sa >= (longint'(1) << (w - 1)))
            sa = sa - (longint'(1) << w);
         if (sb >= (longint'(1) << (w - 1)))
            sb = sb - (longint'(1) << w);
      end
      p  = sa * sb;
      pm = (64'd1 << (2 * w)) - 64'd1;
      return 64'(p) & pm;
   endfunction

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   // One start pulse to all three widths, then watch every done
   task automatic run_op(input logic [31:0] a,
                         input logic [31:0] b,
                         input bit sm);
      logic [63:0] exp [3];
      bit got [3];
      int nb;
      int nd;
      logic [63:0] v;
      for (int i = 0; i < 3; i++) begin
         exp[i] = ref_prod(wid(i), a, b, sm);
         got[i] = 1'b0;
      end
      @(negedge clk);
      in1 = a;
      in2 = b;
      sign_mode = sm;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in1 = $urandom;
      in2 = $urandom;
      sign_mode = ~sm;
      nb = 0;
      nd = 0;
      for (int c = 1; c <= 20; c++) begin
         if (bsy[1]) nb++;
         if (dn[1]) nd++;
         for (int i = 0; i < 3; i++) begin
            if (dn[i] && !got[i]) begin
               got[i] = 1'b1;
               v = outv(i);
               chk($sformatf("prod w%0d %0h*%0h s%0d",
                   wid(i), a, b, sm), v, exp[i]);
               chk($sformatf("latency w%0d", wid(i)),
                   64'(c), 64'(wid(i) + 1));
               if (i == 1) res8 = v[15:0];
            end
         end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         if (!got[i]) begin
            errors++;
            $display("FAIL timeout w%0d no done", wid(i));
         end
      end
      chk("busy8 cycles", 64'(nb), 64'd9);
      chk("done8 pulses", 64'(nd), 64'd1);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      bit          sm;
      logic [15:0] exp;
   } vec_t;

   vec_t tv [8];

   initial begin
      int d1;
      int nd;
      tv[0] = '{32'd15,   32'd15,   1'b0, 16'h00E1};
      tv[1] = '{32'd255,  32'd255,  1'b0, 16'hFE01};
      tv[2] = '{32'd0,    32'd200,  1'b0, 16'h0000};
      tv[3] = '{32'hFD,   32'd5,    1'b1, 16'hFFF1};
      tv[4] = '{32'h80,   32'h80,   1'b1, 16'h4000};
      tv[5] = '{32'h80,   32'h7F,   1'b1, 16'hC080};
      tv[6] = '{32'h7F,   32'hFF,   1'b1, 16'hFF81};
      tv[7] = '{32'h0,    32'h80,   1'b1, 16'h0000};

      rst = 1'b1;
      start = 1'b1;
      sign_mode = 1'b0;
      in1 = 32'd3;
      in2 = 32'd3;
      res8 = '0;
      repeat (3) @(negedge clk);
      chk("reset out8", {48'd0, o8}, 64'd0);
      chk("reset out16", {32'd0, o16}, 64'd0);
      chk("reset busy", {61'd0, bsy}, 64'd0);
      chk("reset done", {61'd0, dn}, 64'd0);
      rst = 1'b0;
      start = 1'b0;

      for (int t = 0; t < 8; t++) begin
         run_op(tv[t].a, tv[t].b, tv[t].sm);
         chk($sformatf("table %0d", t),
             {48'd0, res8}, {48'd0, tv[t].exp});
      end

      for (int r = 0; r < 25; r++)
         run_op($urandom, $urandom, 1'($urandom_range(0, 1)));

      // start held through the op while operands change mid-RUN
      @(negedge clk);
      in1 = 32'd7;
      in2 = 32'd9;
      sign_mode = 1'b0;
      start = 1'b1;
      @(negedge clk);
      d1 = 0;
      for (int c = 1; c <= 22; c++) begin
         if (c == 3) begin
            in1 = 32'd3;
            in2 = 32'd5;
         end
         if (c == 10)
            chk("idle gap busy8", {63'd0, bsy[1]}, 64'd0);
         if (dn[1]) begin
            if (d1 == 0) begin
               chk("held start out", {48'd0, o8}, 64'd63);
               chk("held start t1", 64'(c), 64'd9);
            end else if (d1 == 1) begin
               chk("second op out", {48'd0, o8}, 64'd15);
               chk("second op t2", 64'(c), 64'd19);
            end
            d1++;
         end
         @(negedge clk);
      end
      chk("held start dones", 64'(d1), 64'd2);
      start = 1'b0;
      repeat (25) @(negedge clk);

      // reset during the 4th RUN cycle
      in1 = 32'd10;
      in2 = 32'd10;
      sign_mode = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst busy8", {63'd0, bsy[1]}, 64'd0);
      chk("rst done8", {63'd0, dn[1]}, 64'd0);
      chk("rst out8", {48'd0, o8}, 64'd0);
      nd = 0;
      for (int c = 0; c < 15; c++) begin
         if (dn != 3'b000) nd++;
         @(negedge clk);
      end
      chk("no done after rst", 64'(nd), 64'd0);
      chk("out held after rst", {48'd0, o8}, 64'd0);
      run_op(32'd6, 32'd7, 1'b0);
      chk("post rst 6*7", {48'd0, res8}, 64'd42);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
